// File: rtl/clock_display_scan_if.sv
// Bundle between the time counters / board pins and the display scanner.
// The master side supplies the time fields and the set selection.
// The slave side (the scanner) drives the active-low display pins.
interface clock_display_scan_if;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] set_sel;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    modport master (output hour, minute, second, set_sel, input seg, dp, an);
    modport slave  (input hour, minute, second, set_sel, output seg, dp, an);
endinterface

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment driver showing HH.MM.SS on a
// common-anode display. Time fields are snapshotted once per frame so a
// frame never mixes old and new values. The field being set blinks.
module clock_display_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    clock_display_scan_if.slave   bus
);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Map a decimal digit to the active-low g..a pattern.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Split a 0..59 value into {tens, units} using compare/subtract only.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        if      (v >= 6'd50) begin t = 4'd5; r = v - 6'd50; end
        else if (v >= 6'd40) begin t = 4'd4; r = v - 6'd40; end
        else if (v >= 6'd30) begin t = 4'd3; r = v - 6'd30; end
        else if (v >= 6'd20) begin t = 4'd2; r = v - 6'd20; end
        else if (v >= 6'd10) begin t = 4'd1; r = v - 6'd10; end
        else                 begin t = 4'd0; r = v;          end
        return {t, r[3:0]};
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]         digit_q, digit_d;
    logic [4:0]         hour_q;
    logic [5:0]         minute_q, second_q;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [1:0]         set_sel_q;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [5:0]         an_q, an_d;

    logic       scan_wrap, frame_start, sel_chg, blink_eff, blank;
    logic [7:0] h_bcd, m_bcd, s_bcd;
    logic       h_bad, m_bad, s_bad;
    logic [3:0] dig_val;
    logic       dig_bad;
    logic [1:0] dig_field;

    assign scan_wrap   = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign frame_start = (scan_cnt_q == '0) && (digit_q == 3'd0);
    assign sel_chg     = (bus.set_sel != set_sel_q);
    // A fresh selection is shown at once, even on the edge it is first seen.
    assign blink_eff   = sel_chg | blink_on_q;

    assign h_bcd = to_bcd({1'b0, hour_q});
    assign m_bcd = to_bcd(minute_q);
    assign s_bcd = to_bcd(second_q);
    assign h_bad = (hour_q   >= 5'd24);
    assign m_bad = (minute_q >= 6'd60);
    assign s_bad = (second_q >= 6'd60);

    // Scan and blink counters next state; a selection change beats a blink wrap.
    always_comb begin
        scan_cnt_d  = scan_cnt_q + 1'b1;
        digit_d     = digit_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_on_d  = blink_on_q;
        if (scan_wrap) begin
            scan_cnt_d = '0;
            digit_d    = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
        end
        if (sel_chg) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end
    end

    // Select the current digit's value and build the next pin pattern.
    always_comb begin
        dig_val   = 4'd0;
        dig_bad   = 1'b0;
        dig_field = digit_q[2:1] + 2'd1;
        case (digit_q)
            3'd0:    begin dig_val = h_bcd[7:4]; dig_bad = h_bad; end
            3'd1:    begin dig_val = h_bcd[3:0]; dig_bad = h_bad; end
            3'd2:    begin dig_val = m_bcd[7:4]; dig_bad = m_bad; end
            3'd3:    begin dig_val = m_bcd[3:0]; dig_bad = m_bad; end
            3'd4:    begin dig_val = s_bcd[7:4]; dig_bad = s_bad; end
            3'd5:    begin dig_val = s_bcd[3:0]; dig_bad = s_bad; end
            default: begin dig_val = 4'd0;       dig_bad = 1'b0;  end
        endcase
        blank = !blink_eff && (bus.set_sel != 2'b00) && (bus.set_sel == dig_field);
        an_d  = ~(6'b000001 << digit_q);
        seg_d = dig_bad ? SEG_DASH : seg_code(dig_val);
        dp_d  = !((digit_q == 3'd1) || (digit_q == 3'd3));
        if (blank) begin
            an_d  = 6'b111111;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    // Scan position, once-per-frame snapshot and blink state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            digit_q     <= 3'd0;
            hour_q      <= 5'd0;
            minute_q    <= 6'd0;
            second_q    <= 6'd0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            set_sel_q   <= 2'b00;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            set_sel_q   <= bus.set_sel;
            if (frame_start) begin
                hour_q   <= bus.hour;
                minute_q <= bus.minute;
                second_q <= bus.second;
            end
        end
    end

    // Registered pins, one cycle behind the internal scan state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= 6'b111111;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.an  = an_q;
endmodule
